// File: rtl/channel_fifo_responder.sv
`default_nettype none
//============================================================================
// Module      : channel_fifo_responder
// Description : Responder end of the HLS channel handshake. Buffers
//               WIDTH-bit words from a producer kernel in a circular FIFO
//               of DEPTH entries and hands them to a consumer kernel
//               through a registered out_data port.
//
// Ports       : clk          - single clock, rising-edge active
//               rst          - asynchronous, active-low reset
//               in_data      - write data, sampled when write_valid is high
//               write_valid  - producer request, one word per high cycle
//               write_ready  - at least one entry free
//               read_valid   - consumer request, one word per high cycle
//               read_ready   - at least one entry occupied
//               out_data     - registered read data, held between reads
//
// Revision    : 1.0 - initial release
//============================================================================
module channel_fifo_responder #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             write_valid,
    output logic             write_ready,
    input  logic             read_valid,
    output logic             read_ready,
    output logic [WIDTH-1:0] out_data
);

    // Pointer width; count needs one extra bit to represent "full".
    localparam int              c_ADDR_W     = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0] c_FULL_COUNT = (c_ADDR_W + 1)'(DEPTH);
    localparam logic [c_ADDR_W:0] c_ONE        = (c_ADDR_W + 1)'(1);

    // Storage is deliberately left unreset; only the bookkeeping is cleared.
    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic [WIDTH-1:0]    r_out_data;

    logic w_write_ready;
    logic w_read_ready;
    logic w_write_fire;
    logic w_read_fire;

    //------------------------------------------------------------------------
    // Handshake decode. The ready flags depend on the registered count only,
    // so there is no combinational path from either valid to either ready.
    // Because of that, a same-cycle read on an empty FIFO is refused and a
    // same-cycle write on a full FIFO is refused: a read can never bypass a
    // write that lands on the same edge.
    //------------------------------------------------------------------------
    always_comb begin
        w_write_ready = (r_count != c_FULL_COUNT);
        w_read_ready  = (r_count != '0);
        w_write_fire  = write_valid & w_write_ready;
        w_read_fire   = read_valid  & w_read_ready;
    end

    //------------------------------------------------------------------------
    // Storage array write port.
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_write_fire) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    //------------------------------------------------------------------------
    // Pointers, occupancy and the output register. DEPTH is a power of two,
    // so the pointers wrap naturally when they overflow.
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_data <= '0;
        end else begin
            if (w_write_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_read_fire) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_out_data <= r_mem[r_rd_ptr];
            end

            // Simultaneous accepted read and write leave occupancy unchanged.
            if (w_write_fire && !w_read_fire) begin
                r_count <= r_count + c_ONE;
            end else if (w_read_fire && !w_write_fire) begin
                r_count <= r_count - c_ONE;
            end
        end
    end

    assign write_ready = w_write_ready;
    assign read_ready  = w_read_ready;
    assign out_data    = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_channel_fifo_responder.sv
`default_nettype none
//============================================================================
// Module      : tb_channel_fifo_responder
// Description : Directed self-checking bench for channel_fifo_responder
//               (WIDTH=32, DEPTH=16). Inputs change 1 time unit after a
//               rising edge; outputs are sampled at the same point.
// Revision    : 1.0 - initial release
//============================================================================
module tb_channel_fifo_responder;

    localparam int c_WIDTH = 32;
    localparam int c_DEPTH = 16;

    logic               clk;
    logic               rst;
    logic [c_WIDTH-1:0] in_data;
    logic               write_valid;
    logic               write_ready;
    logic               read_valid;
    logic               read_ready;
    logic [c_WIDTH-1:0] out_data;

    int n_checks;
    int n_errors;
    int sum;

    channel_fifo_responder #(
        .WIDTH (c_WIDTH),
        .DEPTH (c_DEPTH)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .write_valid (write_valid),
        .write_ready (write_ready),
        .read_valid  (read_valid),
        .read_ready  (read_ready),
        .out_data    (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] value);
        in_data     = value;
        write_valid = 1'b1;
        tick();
        write_valid = 1'b0;
    endtask

    // Single read pulse; out_data is sampled the cycle after the pulse.
    task automatic read_expect(input string tag, input logic [31:0] expected);
        read_valid = 1'b1;
        tick();
        read_valid = 1'b0;
        check_value(tag, out_data, expected);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        sum         = 0;
        rst         = 1'b0;
        in_data     = '0;
        write_valid = 1'b0;
        read_valid  = 1'b0;

        // ---------------- Reset state ----------------
        #2;
        check_value("reset_out_data",    out_data,    0);
        check_value("reset_write_ready", write_ready, 1);
        check_value("reset_read_ready",  read_ready,  0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        tick();

        // ---------------- Basic write 3,5,7,9 then paced reads ----------------
        write_word(3);
        check_value("t1_read_ready_after_first_write", read_ready, 1);
        write_word(5);
        write_word(7);
        write_word(9);
        for (int i = 0; i < 4; i++) begin
            read_valid = 1'b1;
            tick();
            read_valid = 1'b0;
            check_value("t1_read_data", out_data, 3 + 2 * i);
            sum += out_data;
            tick();
            check_value("t1_read_data_held", out_data, 3 + 2 * i);
        end
        check_value("t1_read_ready_empty", read_ready, 0);
        check_value("t1_sum", sum, 24);

        // ---------------- Fill to full, overflow dropped ----------------
        for (int i = 0; i < 16; i++) begin
            write_word(i);
            check_value("t2_write_ready_fill", write_ready, (i == 15) ? 0 : 1);
        end
        write_word(99);
        check_value("t2_write_ready_still_full", write_ready, 0);
        for (int i = 0; i < 16; i++) begin
            read_expect("t2_read_order", i);
        end
        check_value("t2_read_ready_empty", read_ready, 0);
        check_value("t2_write_ready_empty", write_ready, 1);

        // ---------------- Empty: simultaneous read and write ----------------
        in_data     = 42;
        write_valid = 1'b1;
        read_valid  = 1'b1;
        tick();
        write_valid = 1'b0;
        read_valid  = 1'b0;
        check_value("t3_out_data_unchanged", out_data, 15);
        check_value("t3_read_ready", read_ready, 1);
        read_expect("t3_read_42", 42);
        check_value("t3_empty_again", read_ready, 0);

        // ---------------- Full: simultaneous read and write ----------------
        for (int i = 0; i < 16; i++) begin
            write_word(200 + i);
        end
        check_value("t4_full", write_ready, 0);
        in_data     = 77;
        write_valid = 1'b1;
        read_valid  = 1'b1;
        tick();
        write_valid = 1'b0;
        read_valid  = 1'b0;
        check_value("t4_oldest_word", out_data, 200);
        check_value("t4_count_15_write_ready", write_ready, 1);
        write_word(77);
        check_value("t4_full_after_77", write_ready, 0);
        for (int i = 1; i < 16; i++) begin
            read_expect("t4_drain", 200 + i);
        end
        read_expect("t4_drain_77", 77);
        check_value("t4_empty", read_ready, 0);

        // ---------------- 40 words interleaved, occupancy held at 3 ----------------
        write_word(100);
        write_word(101);
        write_word(102);
        for (int k = 0; k < 37; k++) begin
            in_data     = 103 + k;
            write_valid = 1'b1;
            read_valid  = 1'b1;
            tick();
            write_valid = 1'b0;
            read_valid  = 1'b0;
            check_value("t5_stream", out_data, 100 + k);
        end
        read_expect("t5_tail", 137);
        read_expect("t5_tail", 138);
        read_expect("t5_tail", 139);
        check_value("t5_empty", read_ready, 0);

        // ---------------- Asynchronous reset mid-operation ----------------
        write_word(1);
        write_word(2);
        read_expect("t6_pre_reset_read", 1);
        #3 rst = 1'b0;
        #1;
        check_value("t6_async_out_data",    out_data,    0);
        check_value("t6_async_read_ready",  read_ready,  0);
        check_value("t6_async_write_ready", write_ready, 1);
        @(posedge clk);
        #4 rst = 1'b1;
        tick();
        read_expect("t6_read_after_reset", 0);
        check_value("t6_read_ready_after_reset", read_ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/channel_fifo_responder.md
Name: channel_fifo_responder

Overview:
- Responder (channel) end of the HLS channel handshake used by generated kernels such as the reduce blocks.
- Buffers WIDTH-bit words in a circular FIFO of DEPTH entries.
- Accepts one-cycle write_valid pulses from a producer kernel and read_valid pulses from a consumer kernel.
- Advertises write_ready / read_ready and presents read data on a registered out_data port held between reads.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 16, number of storage entries; power of two, >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  write data; sampled on the edge where write_valid is high.
- write_valid  input  1  producer write request; one word per high cycle.
- write_ready  output  1  high when at least one entry is free.
- read_valid  input  1  consumer read request; one word per high cycle.
- read_ready  output  1  high when at least one entry is occupied.
- out_data  output  WIDTH  registered read data, loaded on an accepted read.

Behaviour:
- State: storage array mem[DEPTH]; wr_ptr and rd_ptr, each log2(DEPTH) bits; count, log2(DEPTH)+1 bits; out_data register.
- Reset (rst low, asynchronous assert, released synchronously by the next clk edge):
  - wr_ptr=0, rd_ptr=0, count=0, out_data=0.
  - Therefore write_ready=1 and read_ready=0.
  - mem is not reset.
- write_ready = (count != DEPTH) and read_ready = (count != 0). Both are decoded from the registered count only, with no combinational path from write_valid or read_valid.
- Write accepted = write_valid & write_ready:
  - mem[wr_ptr] <= in_data.
  - wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Read accepted = read_valid & read_ready:
  - out_data <= mem[rd_ptr].
  - rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on both or neither.
- Latency:
  - A word written at edge t makes read_ready high from cycle t+1. An empty FIFO with a write at t gives read_ready=1 in the cycle after t.
  - A read accepted at edge t gives out_data valid from cycle t+1. The consumer samples out_data the cycle after its read_valid pulse.
  - out_data holds until the next accepted read.
- Rejected requests:
  - write_valid with write_ready=0 (full): no state change; the word is dropped.
  - read_valid with read_ready=0 (empty): no state change; out_data retains its previous value.
- Simultaneous read and write:
  - Empty: the write is accepted and the read is ignored (read_ready was 0); count becomes 1.
  - Full: the read is accepted and the write is rejected (write_ready was 0); count becomes DEPTH-1.
  - Otherwise both are accepted and count is unchanged.
  - Reads never bypass a same-cycle write.
- Multi-cycle valid: each high cycle is a separate request. The block does not detect edges.
- Reset mid-operation: all buffered words are discarded immediately; out_data reads 0; the ready outputs return to their reset values asynchronously.
- Ordering: strict FIFO; wrap-around is transparent to the user.

Test Plan:
- Reset, then write 3, 5, 7, 9 on consecutive cycles, then four read pulses two cycles apart -> out_data shows 3, 5, 7, 9 the cycle after each pulse; read_ready=0 after the 4th read; a consumer sum equals 24.
- DEPTH=16: write 0..15 -> write_ready drops in the cycle after the 16th write; a 17th write of 99 is dropped; 16 reads return 0..15 in order.
- Empty FIFO, write_valid and read_valid both high in the same cycle with in_data=42 -> count=1, out_data unchanged; the next read returns 42.
- Full FIFO, simultaneous read and write (in_data=77) -> out_data=oldest word, count=15, 77 not stored; the next write of 77 is accepted.
- Write/read 40 words (values 100..139) interleaved, keeping occupancy between 1 and 4 -> pointers wrap at least twice; all 40 read back in order, no loss or duplication.
- Write 2 words, then assert rst low mid-cycle for 1 cycle -> out_data=0, read_ready=0, write_ready=1 immediately; a subsequent read_valid changes nothing.
